// File: rtl/multdiv_pkg.sv
// Shared constants, state encoding and helpers for the iterative multiply/divide controller.
package multdiv_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  localparam int MUL_ITERS   = 32;
  localparam int DIV_ITERS   = 32;
  localparam int MUL_LATENCY = 33;
  localparam int DIV_LATENCY = 36;

  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_ITER,
    ST_DIV_NEG_A,
    ST_DIV_NEG_B,
    ST_DIV_ITER,
    ST_DIV_FIX,
    ST_DONE
  } state_t;

  // Counter runs from iters-1 down to 0, so the zero flag marks the final iteration.
  function automatic logic [CNT_W-1:0] iterLoad(input int iters);
    return CNT_W'(iters - 1);
  endfunction

endpackage

// File: rtl/multdiv_iter_counter.sv
// 6-bit iteration down-counter with load, enable and zero flag.
module multdiv_iter_counter
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_loadValue,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Saturates at zero so a stray enable cannot wrap the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) controller driving a shared ALU.
// Optional MULTDIV_DBZ_FAST_EN: divide-by-zero is resolved at the start edge instead of after full latency.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_m;
  logic             r_q1;
  logic             r_signA;
  logic             r_signB;
  logic             r_dbz;
  logic             r_ovf;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;

  logic             w_startMul;
  logic             w_startDiv;
  logic             w_start;
  logic             w_dbzFast;
  logic             w_cntLoad;
  logic [CNT_W-1:0] w_cntLoadValue;
  logic             w_cntEnable;
  logic             w_cntZero;
  logic [CNT_W-1:0] w_cntCount;

  logic [1:0]       w_boothSel;
  logic             w_mulPass;
  logic [WIDTH-1:0] w_mulSum;
  logic             w_mulSign;
  logic [WIDTH-1:0] w_mulHiNext;
  logic [WIDTH-1:0] w_mulLoNext;
  logic [WIDTH-1:0] w_remShift;
  logic             w_borrow;

  assign w_startMul = ctrl_MULT;
  assign w_startDiv = ctrl_DIV & ~ctrl_MULT;
  assign w_start    = w_startMul | w_startDiv;

`ifdef MULTDIV_DBZ_FAST_EN
  assign w_dbzFast = w_startDiv && (data_operandB == '0);
`else
  assign w_dbzFast = 1'b0;
`endif

  // Booth step: the ALU's sign is corrected by overflow so the arithmetic shift stays exact.
  assign w_boothSel  = {r_lo[0], r_q1};
  assign w_mulPass   = (w_boothSel == 2'b00) || (w_boothSel == 2'b11);
  assign w_mulSum    = w_mulPass ? r_hi : alu_result;
  assign w_mulSign   = w_mulPass ? r_hi[WIDTH-1] : (alu_result[WIDTH-1] ^ alu_overflow);
  assign w_mulHiNext = {w_mulSign, w_mulSum[WIDTH-1:1]};
  assign w_mulLoNext = {w_mulSum[0], r_lo[WIDTH-1:1]};

  // Unsigned R' < D derived from the signed ALU subtract.
  assign w_remShift = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_borrow   = (~w_remShift[WIDTH-1] & r_m[WIDTH-1]) |
                      (~(w_remShift[WIDTH-1] ^ r_m[WIDTH-1]) & alu_result[WIDTH-1]);

  assign w_cntLoad      = w_start | (r_state == ST_DIV_NEG_B);
  assign w_cntLoadValue = w_startMul ? iterLoad(MUL_ITERS) : iterLoad(DIV_ITERS);

  multdiv_iter_counter u_iterCounter (
    .clock       (clock),
    .reset       (reset),
    .i_load      (w_cntLoad),
    .i_loadValue (w_cntLoadValue),
    .i_enable    (w_cntEnable),
    .o_count     (w_cntCount),
    .o_zero      (w_cntZero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    alu_opcode   = ALU_ADD;
    alu_operandA = '0;
    alu_operandB = '0;
    w_cntEnable  = 1'b0;
    case (r_state)
      ST_MUL_ITER: begin
        alu_operandA = r_hi;
        alu_operandB = w_mulPass ? '0 : r_m;
        alu_opcode   = (w_boothSel == 2'b10) ? ALU_SUB : ALU_ADD;
        w_cntEnable  = 1'b1;
        if (w_cntZero) w_nextState = ST_DONE;
      end
      ST_DIV_NEG_A: begin
        alu_opcode   = ALU_SUB;
        alu_operandB = r_lo;
        w_nextState  = ST_DIV_NEG_B;
      end
      ST_DIV_NEG_B: begin
        alu_opcode   = ALU_SUB;
        alu_operandB = r_m;
        w_nextState  = ST_DIV_ITER;
      end
      ST_DIV_ITER: begin
        alu_opcode   = ALU_SUB;
        alu_operandA = w_remShift;
        alu_operandB = r_m;
        w_cntEnable  = 1'b1;
        if (w_cntZero) w_nextState = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        alu_opcode   = ALU_SUB;
        alu_operandB = r_lo;
        w_nextState  = ST_DONE;
      end
      ST_DONE:  w_nextState = ST_IDLE;
      default:  w_nextState = ST_IDLE;
    endcase
    if (w_startMul) begin
      w_nextState = ST_MUL_ITER;
    end else if (w_startDiv) begin
      w_nextState = w_dbzFast ? ST_DONE : ST_DIV_NEG_A;
    end
  end

  // Divide keeps the dividend/quotient in r_lo, the remainder in r_hi and the divisor in r_m.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hi        <= '0;
      r_lo        <= '0;
      r_m         <= '0;
      r_q1        <= 1'b0;
      r_signA     <= 1'b0;
      r_signB     <= 1'b0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_result    <= '0;
      r_exception <= 1'b0;
    end else if (w_startMul) begin
      r_hi <= '0;
      r_lo <= data_operandB;
      r_q1 <= 1'b0;
      r_m  <= data_operandA;
    end else if (w_startDiv) begin
      r_hi    <= '0;
      r_lo    <= data_operandA;
      r_m     <= data_operandB;
      r_q1    <= 1'b0;
      r_signA <= data_operandA[WIDTH-1];
      r_signB <= data_operandB[WIDTH-1];
      r_dbz   <= (data_operandB == '0);
      r_ovf   <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
      if (w_dbzFast) begin
        r_result    <= '0;
        r_exception <= 1'b1;
      end
    end else begin
      case (r_state)
        ST_MUL_ITER: begin
          r_hi <= w_mulHiNext;
          r_lo <= w_mulLoNext;
          r_q1 <= r_lo[0];
          if (w_cntZero) begin
            r_result    <= w_mulLoNext;
            r_exception <= (w_mulHiNext != {WIDTH{w_mulLoNext[WIDTH-1]}});
          end
        end
        ST_DIV_NEG_A: begin
          if (r_signA) r_lo <= alu_result;
        end
        ST_DIV_NEG_B: begin
          if (r_signB) r_m <= alu_result;
          r_hi <= '0;
        end
        ST_DIV_ITER: begin
          r_hi <= w_borrow ? w_remShift : alu_result;
          r_lo <= {r_lo[WIDTH-2:0], ~w_borrow};
        end
        ST_DIV_FIX: begin
          if (r_dbz) begin
            r_result    <= '0;
            r_exception <= 1'b1;
          end else begin
            r_result    <= (r_signA ^ r_signB) ? alu_result : r_lo;
            r_exception <= r_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = (r_state == ST_DONE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: behavioural ALU, directed table, corner sequences, random ops.
module tb_multdiv_ctrl;

  localparam int TIMEOUT = 100;
`ifdef MULTDIV_DBZ_FAST_EN
  localparam bit FAST_DBZ = 1'b1;
`else
  localparam bit FAST_DBZ = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  typedef struct {
    logic        isDiv;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
    logic        expExc;
  } vec_t;

  vec_t        vecs[12];
  int          checkCount;
  int          passCount;
  int          badOpcode;
  int          cycles;
  int          rdyCount;
  logic [31:0] gotRes;
  logic        gotExc;
  logic        extraRdy;
  logic [31:0] heldRes;
  logic [31:0] refRes;
  logic        refExc;
  logic        rIsDiv;
  logic [31:0] rA;
  logic [31:0] rB;

  multdiv_ctrl #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .alu_opcode     (alu_opcode),
    .alu_operandA   (alu_operandA),
    .alu_operandB   (alu_operandB),
    .alu_result     (alu_result),
    .alu_overflow   (alu_overflow),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural 32-bit ALU the controller borrows: ADD/SUB with signed overflow.
  always_comb begin
    alu_result   = 32'h0;
    alu_overflow = 1'b0;
    if (alu_opcode == 5'b00001) begin
      alu_result   = alu_operandA - alu_operandB;
      alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end else begin
      alu_result   = alu_operandA + alu_operandB;
      alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end
  end

  always @(negedge clock) begin
    if (!reset && (alu_opcode != 5'b00000) && (alu_opcode != 5'b00001)) badOpcode++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model from plain signed arithmetic.
  function automatic void refModel(input logic isDiv, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic exc);
    longint      p;
    logic [63:0] pBits;
    logic [31:0] lo;
    if (!isDiv) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      pBits = p;
      lo    = pBits[31:0];
      res   = lo;
      exc   = (p != longint'($signed(lo)));
    end else if (b == 32'h0) begin
      res = 32'h0;
      exc = 1'b1;
    end else if ((a == 32'h80000000) && (b == 32'hFFFFFFFF)) begin
      res = 32'h80000000;
      exc = 1'b1;
    end else begin
      res = $signed(a) / $signed(b);
      exc = 1'b0;
    end
  endfunction

  function automatic int expLatency(input logic isDiv, input logic [31:0] b);
    if (!isDiv) return 33;
    if (FAST_DBZ && (b == 32'h0)) return 1;
    return 36;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Pulses a start, waits (bounded) for RDY and samples result, exception and the pulse width.
  task automatic applyStimulus(input logic isDiv, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output logic [31:0] res, output logic exc,
                               output logic extra, output logic [31:0] held);
    @(negedge clock);
    ctrl_MULT     = ~isDiv;
    ctrl_DIV      = isDiv;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    lat = 1;
    while (!data_resultRDY && (lat < TIMEOUT)) begin
      @(negedge clock);
      lat++;
    end
    res = data_result;
    exc = data_exception;
    @(negedge clock);
    extra = data_resultRDY;
    held  = data_result;
  endtask

  initial begin
    checkCount    = 0;
    passCount     = 0;
    badOpcode     = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'h0;
    data_operandB = 32'h0;

    vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    vecs[2]  = '{1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[3]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[5]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[6]  = '{1'b1, 32'd100,      32'd7,        32'd14,       1'b0};
    vecs[7]  = '{1'b1, 32'd100,      32'd0,        32'h00000000, 1'b1};
    vecs[8]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[9]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[11] = '{1'b1, 32'd5,        32'h80000000, 32'h00000000, 1'b0};

    repeat (2) @(negedge clock);
    checkOutput("reset result", data_result, 32'h0);
    checkOutput("reset exception", {31'h0, data_exception}, 32'h0);
    checkOutput("reset rdy", {31'h0, data_resultRDY}, 32'h0);
    checkOutput("reset opcode", {27'h0, alu_opcode}, 32'h0);
    checkOutput("reset aluA", alu_operandA, 32'h0);
    checkOutput("reset aluB", alu_operandB, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].isDiv, vecs[i].a, vecs[i].b, cycles, gotRes, gotExc, extraRdy, heldRes);
      $display("[TB] vec %0d %s a=0x%08h b=0x%08h", i, vecs[i].isDiv ? "DIV" : "MUL", vecs[i].a, vecs[i].b);
      checkOutput("vec latency", 32'(cycles), 32'(expLatency(vecs[i].isDiv, vecs[i].b)));
      checkOutput("vec result", gotRes, vecs[i].expResult);
      checkOutput("vec exception", {31'h0, gotExc}, {31'h0, vecs[i].expExc});
      checkOutput("vec rdy width", {31'h0, extraRdy}, 32'h0);
      checkOutput("vec result hold", heldRes, vecs[i].expResult);
    end

    // Restart: a divide issued mid-multiply aborts it without a RDY pulse.
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd6;
    data_operandB = 32'd6;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    rdyCount  = 0;
    repeat (9) begin
      if (data_resultRDY) rdyCount++;
      @(negedge clock);
    end
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd20;
    data_operandB = 32'd3;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    cycles   = 1;
    while (!data_resultRDY && (cycles < TIMEOUT)) begin
      @(negedge clock);
      cycles++;
    end
    checkOutput("abort no mul rdy", 32'(rdyCount), 32'd0);
    checkOutput("abort div latency", 32'(cycles), 32'd36);
    checkOutput("abort div result", data_result, 32'd6);

    // Asynchronous reset in the middle of a divide.
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd1000;
    data_operandB = 32'd7;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (15) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset result", data_result, 32'h0);
    checkOutput("midreset exception", {31'h0, data_exception}, 32'h0);
    checkOutput("midreset rdy", {31'h0, data_resultRDY}, 32'h0);
    checkOutput("midreset opcode", {27'h0, alu_opcode}, 32'h0);
    checkOutput("midreset aluA", alu_operandA, 32'h0);
    checkOutput("midreset aluB", alu_operandB, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset    = 1'b0;
    rdyCount = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdyCount++;
    end
    checkOutput("postreset no rdy", 32'(rdyCount), 32'd0);
    applyStimulus(1'b0, 32'd5, 32'd5, cycles, gotRes, gotExc, extraRdy, heldRes);
    checkOutput("postreset latency", 32'(cycles), 32'd33);
    checkOutput("postreset result", gotRes, 32'd25);
    checkOutput("postreset exception", {31'h0, gotExc}, 32'h0);

    for (int n = 0; n < 40; n++) begin
      rIsDiv = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin rA = $urandom; rB = $urandom; end
        1: begin rA = $urandom; rB = 32'($signed($urandom_range(0, 40)) - 20); end
        2: begin rA = 32'($signed($urandom_range(0, 2000)) - 1000); rB = 32'($signed($urandom_range(0, 60)) - 30); end
        default: begin rA = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'($urandom)}; rB = 32'($urandom_range(0, 65535)); end
      endcase
      refModel(rIsDiv, rA, rB, refRes, refExc);
      applyStimulus(rIsDiv, rA, rB, cycles, gotRes, gotExc, extraRdy, heldRes);
      if (gotRes !== refRes || gotExc !== refExc)
        $display("[TB] random %0d %s a=0x%08h b=0x%08h", n, rIsDiv ? "DIV" : "MUL", rA, rB);
      checkOutput("rand latency", 32'(cycles), 32'(expLatency(rIsDiv, rB)));
      checkOutput("rand result", gotRes, refRes);
      checkOutput("rand exception", {31'h0, gotExc}, {31'h0, refExc});
    end

    checkOutput("alu opcode legal", 32'(badOpcode), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
